// File: rtl/mmv_sequencer_if.sv
// mmv_sequencer_if: memory read port and input-FIFO write port between the
// matrix-vector sequencer (master) and the memory / FIFO fabric (slave).
interface mmv_sequencer_if #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]      mem_address;
    logic                       mem_read;
    logic                       mem_waitrequest;
    logic [COLS*DATA_WIDTH-1:0] mem_readdata;
    logic                       mem_readdatavalid;
    logic [ROWS:0]              fifo_wrreq;
    logic [DATA_WIDTH-1:0]      fifo_wdata;
    logic [ROWS:0]              fifo_wrfull;
    logic [ROWS:0]              fifo_rdempty;

    modport master (
        output mem_address, mem_read, fifo_wrreq, fifo_wdata,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid,
               fifo_wrfull, fifo_rdempty
    );

    modport slave (
        input  mem_address, mem_read, fifo_wrreq, fifo_wdata,
        output mem_waitrequest, mem_readdata, mem_readdatavalid,
               fifo_wrfull, fifo_rdempty
    );
endinterface

// File: rtl/mmv_sequencer.sv
// mmv_sequencer: on start, fetches ROWS A-row words and one B-vector word,
// unpacks each word LSB byte first into FIFOs 0..ROWS, then enables the first
// MAC of the chain for COLS cycles and waits ROWS cycles for the chain to
// drain before raising done.
// Optional read timeout in WAIT: define MMV_SEQ_TIMEOUT_EN.
module mmv_sequencer #(
    parameter int          ROWS       = 8,
    parameter int          COLS       = 8,
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            mac_en,
    output logic            mac_clr,
    mmv_sequencer_if.master bus
);
    localparam int IDX_W  = $clog2(ROWS + 1);
    localparam int CNT_W  = $clog2(COLS + 1);
    localparam int WORD_W = COLS * DATA_WIDTH;

    localparam logic [ROWS:0] SEL0 = {{ROWS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_FILL  = 3'd3,
        S_CALC  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_r, state_next_s;
    logic [IDX_W-1:0]      idx_r, idx_next_s;
    logic [CNT_W-1:0]      byte_cnt_r, byte_cnt_next_s;
    logic [CNT_W-1:0]      col_cnt_r, col_cnt_next_s;
    logic [IDX_W-1:0]      drain_cnt_r, drain_cnt_next_s;
    logic [WORD_W-1:0]     shift_r, shift_next_s;
    logic                  mem_read_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic                  mac_clr_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  start_go_s;
    logic [ROWS:0]         wrreq_s;
    logic                  mac_en_s;
    logic                  unused_rdempty_s;

`ifdef MMV_SEQ_TIMEOUT_EN
    logic [7:0]            tmo_cnt_r, tmo_cnt_next_s;
    logic                  err_r, err_next_s;
`endif

    // only the B FIFO empty flag gates the chain; the A FIFOs drain behind it
    assign unused_rdempty_s = ^bus.fifo_rdempty[ROWS-1:0];

    // start is honoured only when no run is in progress
    assign start_go_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));

    // next-state, datapath updates and the same-cycle FIFO / MAC strobes
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        byte_cnt_next_s  = byte_cnt_r;
        col_cnt_next_s   = col_cnt_r;
        drain_cnt_next_s = drain_cnt_r;
        shift_next_s     = shift_r;
        wrreq_s          = {(ROWS + 1){1'b0}};
        mac_en_s         = 1'b0;
`ifdef MMV_SEQ_TIMEOUT_EN
        tmo_cnt_next_s   = tmo_cnt_r;
        err_next_s       = err_r;
`endif
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_go_s) begin
                    state_next_s     = S_FETCH;
                    idx_next_s       = {IDX_W{1'b0}};
                    byte_cnt_next_s  = {CNT_W{1'b0}};
                    col_cnt_next_s   = {CNT_W{1'b0}};
                    drain_cnt_next_s = {IDX_W{1'b0}};
`ifdef MMV_SEQ_TIMEOUT_EN
                    err_next_s       = 1'b0;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
            S_FETCH: begin
                if (!bus.mem_waitrequest) begin
                    state_next_s   = S_WAIT;
`ifdef MMV_SEQ_TIMEOUT_EN
                    tmo_cnt_next_s = 8'd0;
`endif
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_WAIT: begin
                if (bus.mem_readdatavalid) begin
                    shift_next_s    = bus.mem_readdata;
                    byte_cnt_next_s = {CNT_W{1'b0}};
                    state_next_s    = S_FILL;
                end else begin
`ifdef MMV_SEQ_TIMEOUT_EN
                    if (tmo_cnt_r == 8'd254) begin
                        state_next_s = S_DONE;
                        err_next_s   = 1'b1;
                    end else begin
                        tmo_cnt_next_s = tmo_cnt_r + 8'd1;
                    end
`else
                    state_next_s = S_WAIT;
`endif
                end
            end
            S_FILL: begin
                if (!bus.fifo_wrfull[idx_r]) begin
                    wrreq_s      = SEL0 << idx_r;
                    shift_next_s = shift_r >> DATA_WIDTH;
                    if (byte_cnt_r == CNT_W'(COLS - 1)) begin
                        byte_cnt_next_s = {CNT_W{1'b0}};
                        if (idx_r == IDX_W'(ROWS)) begin
                            state_next_s   = S_CALC;
                            col_cnt_next_s = {CNT_W{1'b0}};
                        end else begin
                            idx_next_s   = idx_r + IDX_W'(1);
                            state_next_s = S_FETCH;
                        end
                    end else begin
                        byte_cnt_next_s = byte_cnt_r + CNT_W'(1);
                    end
                end else begin
                    wrreq_s = {(ROWS + 1){1'b0}};
                end
            end
            S_CALC: begin
                mac_en_s = ~bus.fifo_rdempty[ROWS];
                if (mac_en_s) begin
                    if (col_cnt_r == CNT_W'(COLS - 1)) begin
                        col_cnt_next_s   = {CNT_W{1'b0}};
                        drain_cnt_next_s = {IDX_W{1'b0}};
                        state_next_s     = S_DRAIN;
                    end else begin
                        col_cnt_next_s = col_cnt_r + CNT_W'(1);
                    end
                end else begin
                    col_cnt_next_s = col_cnt_r;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_r == IDX_W'(ROWS - 1)) begin
                    drain_cnt_next_s = {IDX_W{1'b0}};
                    state_next_s     = S_DONE;
                end else begin
                    drain_cnt_next_s = drain_cnt_r + IDX_W'(1);
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // state, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            byte_cnt_r    <= {CNT_W{1'b0}};
            col_cnt_r     <= {CNT_W{1'b0}};
            drain_cnt_r   <= {IDX_W{1'b0}};
            shift_r       <= {WORD_W{1'b0}};
            mem_read_r    <= 1'b0;
            mem_address_r <= {ADDR_WIDTH{1'b0}};
            mac_clr_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            idx_r         <= idx_next_s;
            byte_cnt_r    <= byte_cnt_next_s;
            col_cnt_r     <= col_cnt_next_s;
            drain_cnt_r   <= drain_cnt_next_s;
            shift_r       <= shift_next_s;
            mem_read_r    <= (state_next_s == S_FETCH);
            mem_address_r <= (state_next_s == S_FETCH)
                             ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_next_s))
                             : {ADDR_WIDTH{1'b0}};
            mac_clr_r     <= start_go_s;
            busy_r        <= (state_next_s != S_IDLE) && (state_next_s != S_DONE);
            done_r        <= (state_next_s == S_DONE);
        end
    end

`ifdef MMV_SEQ_TIMEOUT_EN
    // read-timeout counter and sticky error flag (cleared by an accepted start)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 8'd0;
            err_r     <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_cnt_next_s;
            err_r     <= err_next_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign busy            = busy_r;
    assign done            = done_r;
    assign mac_clr         = mac_clr_r;
    assign mac_en          = mac_en_s;
    assign bus.mem_read    = mem_read_r;
    assign bus.mem_address = mem_address_r;
    assign bus.fifo_wrreq  = wrreq_s;
    assign bus.fifo_wdata  = shift_r[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_mmv_sequencer.sv
// tb_mmv_sequencer: directed bench for mmv_sequencer. A small memory model
// answers fetches one cycle after acceptance; stalls, full FIFOs and an empty
// B FIFO are injected on demand. A monitor logs every FIFO write and strobe.
`timescale 1ns/1ps
module tb_mmv_sequencer;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam logic [63:0] B_WORD = 64'h1122334455667788;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, done, err, mac_en, mac_clr;

    mmv_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mmv_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err(err), .mac_en(mac_en), .mac_clr(mac_clr), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int stall_left = 0;
    int full_left  = 0;
    int empty_left = 0;
    bit no_valid   = 1'b0;
    bit acc_pend   = 1'b0;
    logic [AW-1:0] acc_addr = '0;

    int m = 0;
    int start_m = 0, done_m = -1, last_en_m = -1, acc_m = -1, clr_m = -1, first_addr = -1;
    int wr_cnt [ROWS+1] = '{default: 0};
    logic [DW-1:0] got [ROWS+1][COLS];
    int tot_wr = 0, en_cnt = 0, clr_cnt = 0, multi_hot = 0;
    int wr_while_full = 0, en_while_empty = 0, stall_hold = 0;
    bit done_prev = 1'b0;

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        logic [63:0] w;
        if (a < 32'(ROWS)) w = 64'h0807060504030201 + 64'h0101010101010101 * 64'(a);
        else               w = B_WORD;
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_byte(input int f, input int j);
        if (f < ROWS) return 8'(j + 1 + f);
        case (j)
            0: return 8'h88;
            1: return 8'h77;
            2: return 8'h66;
            3: return 8'h55;
            4: return 8'h44;
            5: return 8'h33;
            6: return 8'h22;
            default: return 8'h11;
        endcase
    endfunction

    // memory / FIFO stimulus at the falling edge, then monitor 1 ns later
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_waitrequest   = 1'b0;
            bus.mem_readdatavalid = 1'b0;
            bus.mem_readdata      = 64'd0;
            bus.fifo_wrfull       = '0;
            bus.fifo_rdempty      = '0;
            acc_pend              = 1'b0;
        end else begin
            bus.mem_readdatavalid = acc_pend && !no_valid;
            bus.mem_readdata      = acc_pend ? mem_word(acc_addr) : 64'd0;
            if (bus.mem_read && bus.mem_address == 32'd4 && stall_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bus.mem_waitrequest = 1'b0;
            end
            acc_pend = bus.mem_read && !bus.mem_waitrequest;
            acc_addr = bus.mem_address;
            bus.fifo_wrfull = '0;
            if (wr_cnt[2] == 3 && full_left > 0) begin
                bus.fifo_wrfull[2] = 1'b1;
                full_left--;
            end
            bus.fifo_rdempty = '0;
            if (tot_wr == (ROWS + 1) * COLS && en_cnt == 3 && empty_left > 0) begin
                bus.fifo_rdempty[ROWS] = 1'b1;
                empty_left--;
            end
        end
        #1;
        m++;
        if (start && !busy) begin
            start_m = m; done_m = -1; last_en_m = -1; acc_m = -1; clr_m = -1; first_addr = -1;
            tot_wr = 0; en_cnt = 0; clr_cnt = 0; multi_hot = 0;
            wr_while_full = 0; en_while_empty = 0; stall_hold = 0;
            for (int f = 0; f <= ROWS; f++) begin
                wr_cnt[f] = 0;
                for (int j = 0; j < COLS; j++) got[f][j] = 8'h00;
            end
        end
        if (!$onehot0(bus.fifo_wrreq)) multi_hot++;
        for (int f = 0; f <= ROWS; f++) begin
            if (bus.fifo_wrreq[f]) begin
                if (bus.fifo_wrfull[f]) wr_while_full++;
                if (wr_cnt[f] < COLS) got[f][wr_cnt[f]] = bus.fifo_wdata;
                wr_cnt[f]++;
                tot_wr++;
            end
        end
        if (mac_en) begin
            en_cnt++;
            last_en_m = m;
            if (bus.fifo_rdempty[ROWS]) en_while_empty++;
        end
        if (mac_clr) begin
            clr_cnt++;
            clr_m = m;
        end
        if (bus.mem_waitrequest && bus.mem_read && bus.mem_address == 32'd4) stall_hold++;
        if (bus.mem_read && first_addr < 0) first_addr = int'(bus.mem_address);
        if (bus.mem_read && !bus.mem_waitrequest && acc_m < 0) acc_m = m;
        if (done && !done_prev) done_m = m;
        done_prev = done;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #2;
            if (done_m >= 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #2;
        n_vec++;
        if ({busy, done, err, mac_en, mac_clr} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mac_en, mac_clr});
        end
        n_vec++;
        if ({bus.mem_read, bus.mem_address} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_mem: got read=%b addr=%h expected 0/0", bus.mem_read, bus.mem_address);
        end
        n_vec++;
        if ({bus.fifo_wrreq, bus.fifo_wdata} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_fifo: got wrreq=%b wdata=%h expected 0/0", bus.fifo_wrreq, bus.fifo_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        do_start();
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL basic_done: got no done expected done within 300 cycles"); end
        n_vec++;
        if (done_m - start_m - 1 !== 106) begin
            n_err++; $display("FAIL basic_latency: got %0d expected 106", done_m - start_m - 1);
        end
        for (int f = 0; f <= ROWS; f++) begin
            n_vec++;
            if (wr_cnt[f] !== COLS) begin
                n_err++; $display("FAIL basic_wrcnt[%0d]: got %0d expected %0d", f, wr_cnt[f], COLS);
            end
            for (int j = 0; j < COLS; j++) begin
                n_vec++;
                if (got[f][j] !== exp_byte(f, j)) begin
                    n_err++; $display("FAIL basic_byte[%0d][%0d]: got %h expected %h", f, j, got[f][j], exp_byte(f, j));
                end
            end
        end
        n_vec++;
        if (multi_hot !== 0) begin n_err++; $display("FAIL basic_onehot: got %0d multi-hot cycles expected 0", multi_hot); end
        n_vec++;
        if (clr_cnt !== 1 || clr_m !== start_m + 1) begin
            n_err++; $display("FAIL basic_clr: got %0d pulses at offset %0d expected 1 at offset 1", clr_cnt, clr_m - start_m);
        end
        n_vec++;
        if (en_cnt !== COLS) begin n_err++; $display("FAIL basic_en_cnt: got %0d expected %0d", en_cnt, COLS); end
        n_vec++;
        if (done_m - last_en_m - 1 !== ROWS) begin
            n_err++; $display("FAIL basic_drain: got %0d expected %0d", done_m - last_en_m - 1, ROWS);
        end
        n_vec++;
        if ({busy, done, err} !== 3'b010) begin
            n_err++; $display("FAIL basic_final: got busy/done/err=%b expected 010", {busy, done, err});
        end
    endtask

    task automatic test_waitrequest();
        bit ok;
        stall_left = 3;
        do_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL wait_done: got no done expected done within 300 cycles"); end
        n_vec++;
        if (done_m - start_m - 1 !== 109) begin
            n_err++; $display("FAIL wait_latency: got %0d expected 109", done_m - start_m - 1);
        end
        n_vec++;
        if (stall_hold !== 3) begin
            n_err++; $display("FAIL wait_hold: got %0d held cycles at addr 4 expected 3", stall_hold);
        end
        n_vec++;
        if (wr_cnt[4] !== COLS || got[4][0] !== 8'h05 || got[4][7] !== 8'h0c) begin
            n_err++; $display("FAIL wait_row4: got cnt=%0d b0=%h b7=%h expected 8/05/0c", wr_cnt[4], got[4][0], got[4][7]);
        end
        n_vec++;
        if (clr_cnt !== 1) begin n_err++; $display("FAIL busy_start_ignored: got %0d clr pulses expected 1", clr_cnt); end
    endtask

    task automatic test_wrfull();
        bit ok;
        full_left = 5;
        do_start();
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL full_done: got no done expected done within 300 cycles"); end
        n_vec++;
        if (done_m - start_m - 1 !== 111) begin
            n_err++; $display("FAIL full_latency: got %0d expected 111", done_m - start_m - 1);
        end
        n_vec++;
        if (wr_while_full !== 0) begin n_err++; $display("FAIL full_wr_during_stall: got %0d expected 0", wr_while_full); end
        n_vec++;
        if (wr_cnt[2] !== COLS) begin n_err++; $display("FAIL full_wrcnt2: got %0d expected %0d", wr_cnt[2], COLS); end
        for (int j = 0; j < COLS; j++) begin
            n_vec++;
            if (got[2][j] !== exp_byte(2, j)) begin
                n_err++; $display("FAIL full_byte[2][%0d]: got %h expected %h", j, got[2][j], exp_byte(2, j));
            end
        end
    endtask

    task automatic test_rdempty();
        bit ok;
        empty_left = 2;
        do_start();
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL empty_done: got no done expected done within 300 cycles"); end
        n_vec++;
        if (done_m - start_m - 1 !== 108) begin
            n_err++; $display("FAIL empty_latency: got %0d expected 108", done_m - start_m - 1);
        end
        n_vec++;
        if (en_cnt !== COLS) begin n_err++; $display("FAIL empty_en_cnt: got %0d expected %0d", en_cnt, COLS); end
        n_vec++;
        if (en_while_empty !== 0) begin n_err++; $display("FAIL empty_en_gated: got %0d expected 0", en_while_empty); end
        n_vec++;
        if (done_m - last_en_m - 1 !== ROWS) begin
            n_err++; $display("FAIL empty_drain: got %0d expected %0d", done_m - last_en_m - 1, ROWS);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        do_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (wr_cnt[3] >= 2) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL midrst_reach_fill3: got no FIFO 3 writes expected 2 within 200 cycles"); end
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_vec++;
        if ({busy, done, err, mac_en, mac_clr, bus.mem_read, bus.fifo_wrreq, bus.fifo_wdata} !== 23'd0) begin
            n_err++; $display("FAIL midrst_outputs: got busy=%b wrreq=%b wdata=%h expected all 0",
                              busy, bus.fifo_wrreq, bus.fifo_wdata);
        end
        repeat (2) @(negedge clk);
        #2;
        n_vec++;
        if ({busy, bus.mem_read, bus.mem_address, bus.fifo_wrreq} !== 43'd0) begin
            n_err++; $display("FAIL midrst_hold: got busy=%b read=%b addr=%h expected 0", busy, bus.mem_read, bus.mem_address);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start();
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL midrst_done: got no done expected done within 300 cycles"); end
        n_vec++;
        if (first_addr !== 0) begin n_err++; $display("FAIL midrst_first_addr: got %0d expected 0", first_addr); end
        n_vec++;
        if (clr_cnt !== 1) begin n_err++; $display("FAIL midrst_clr: got %0d expected 1", clr_cnt); end
        n_vec++;
        if (done_m - start_m - 1 !== 106) begin
            n_err++; $display("FAIL midrst_latency: got %0d expected 106", done_m - start_m - 1);
        end
        for (int j = 0; j < COLS; j++) begin
            n_vec++;
            if (got[3][j] !== exp_byte(3, j)) begin
                n_err++; $display("FAIL midrst_byte[3][%0d]: got %h expected %h", j, got[3][j], exp_byte(3, j));
            end
        end
    endtask

`ifdef MMV_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        no_valid = 1'b1;
        do_start();
        wait_done(400, ok);
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_done: got no done expected done within 400 cycles"); end
        n_vec++;
        if ({done, err, busy} !== 3'b110) begin
            n_err++; $display("FAIL tmo_flags: got done/err/busy=%b expected 110", {done, err, busy});
        end
        n_vec++;
        if (done_m - acc_m !== 256) begin
            n_err++; $display("FAIL tmo_timing: got %0d cycles in WAIT expected 255", done_m - acc_m - 1);
        end
        no_valid = 1'b0;
        do_start();
        #2;
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
        wait_done(300, ok);
        n_vec++;
        if (ok !== 1'b1 || err !== 1'b0 || done_m - start_m - 1 !== 106) begin
            n_err++; $display("FAIL tmo_rerun: got err=%b latency=%0d expected 0/106", err, done_m - start_m - 1);
        end
    endtask
`else
    task automatic test_err_tied();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b expected 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_wrfull();
        test_rdempty();
        test_reset_midrun();
`ifdef MMV_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mmv_sequencer.md
# mmv_sequencer

Controller for the 8-row matrix-vector MAC array. On `start` it fetches the eight A-row words and the one B-vector word from memory. It unpacks each word byte-by-byte into the nine input FIFOs (A0..A7, then B). It then drives the enable and clear of the first MAC in the chain and waits for the chain to drain before flagging `done`. It replaces the ad-hoc FILL/CALC/DONE logic at the top level.

## Interface
Parameters:
- ROWS, 8, number of A rows / MACs; FIFO index ROWS is the B FIFO
- COLS, 8, elements per row; bytes per memory word
- DATA_WIDTH, 8, element width
- ADDR_WIDTH, 32, memory address width
- BASE_ADDR, 0, word address of A row 0; row r at BASE_ADDR+r, B at BASE_ADDR+ROWS

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- busy  out  1  high in any state except IDLE and DONE
- done  out  1  high in DONE
- err  out  1  read timeout flag (see Configuration)
- mem_address  out  ADDR_WIDTH  word address of current fetch
- mem_read  out  1  read request
- mem_waitrequest  in  1  memory stall; request held while high
- mem_readdata  in  COLS*DATA_WIDTH  returned word, byte 0 in bits [DATA_WIDTH-1:0]
- mem_readdatavalid  in  1  mem_readdata valid this cycle
- fifo_wrreq  out  ROWS+1  one-hot FIFO write strobe
- fifo_wdata  out  DATA_WIDTH  byte written to the FIFO selected by fifo_wrreq
- fifo_wrfull  in  ROWS+1  per-FIFO full
- fifo_rdempty  in  ROWS+1  per-FIFO empty
- mac_en  out  1  MAC0 En and B FIFO rdreq; propagates along the chain
- mac_clr  out  1  accumulator clear, one-cycle pulse

## Operation
- States: IDLE, FETCH, WAIT, FILL, CALC, DRAIN, DONE.
- Reset state is IDLE. On reset every output is 0, and the row index, byte count, column count and shift register are all cleared.
- IDLE/DONE, start=1: enter FETCH with idx=0, pulse mac_clr, and clear done and err.
- FETCH: mem_read=1 and mem_address=BASE_ADDR+idx. While mem_waitrequest=1, hold the request and address. When mem_waitrequest=0, the request is accepted; go to WAIT.
- WAIT: on mem_readdatavalid, load the shift register and go to FILL. A mem_readdatavalid in any other state is ignored.
- FILL:
  - Each cycle with fifo_wrfull[idx]=0, assert fifo_wrreq[idx] with fifo_wdata equal to shift register bits [DATA_WIDTH-1:0], then shift right by DATA_WIDTH.
  - If fifo_wrfull[idx]=1, stall with wrreq low and data held.
  - After COLS writes: if idx==ROWS, go to CALC; otherwise increment idx and go to FETCH.
- CALC:
  - mac_en = ~fifo_rdempty[ROWS].
  - The column counter increments only on cycles where mac_en=1.
  - After COLS enables, go to DRAIN.
- DRAIN: mac_en=0 for exactly ROWS cycles, then go to DONE.
- DONE: done=1 and busy=0. State holds until start or rst.
- start while busy is ignored.

## Timing
- mem_read is registered. It rises the cycle after start is sampled.
- Minimum fetch-to-FILL time is 2 cycles: accept, then readdatavalid in the following cycle.
- FILL writes 1 byte/cycle when no FIFO is full.
- Minimum run length, with zero-latency memory and no stalls: (ROWS+1)*(2+COLS) + COLS + ROWS cycles. For defaults this is 106 cycles from the start sample to done rising.
- mac_clr is high for exactly the single cycle after start is sampled. It is never high in CALC.
- fifo_wrreq is never multi-hot and is never asserted outside FILL.
- rst asserted mid-run returns the block to IDLE asynchronously. All strobes drop immediately. A subsequent start begins a full new run; no partial FIFO state is tracked.

## Configuration
- MMV_SEQ_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - If 255 cycles elapse without mem_readdatavalid, go to DONE with err=1 and done=1.
  - err clears on the next accepted start.
- Undefined: WAIT waits indefinitely, and err is tied to 0.

## Test plan
- Memory returns rows 0x0807060504030201+0x0101010101010101*r, plus a B word. Expected: each FIFO r receives bytes in order 01+r..08+r; B FIFO gets its bytes LSB first; done rises at cycle 106.
- mem_waitrequest high for 3 cycles on fetch idx=4. Expected: mem_address holds BASE_ADDR+4 with mem_read=1 throughout; done is delayed by exactly 3 cycles.
- fifo_wrfull[2] forced high for 5 cycles mid-FILL. Expected: no wrreq during the stall, no byte lost or duplicated, and 8 total writes to FIFO 2.
- fifo_rdempty[8] high for 2 cycles in CALC. Expected: mac_en low for those cycles, exactly 8 mac_en cycles total, and DRAIN lasts 8 cycles.
- rst pulsed during FILL idx=3, then start. Expected: all outputs 0 during reset; the new run fetches from idx=0 and mac_clr pulses once.
- MMV_SEQ_TIMEOUT_EN defined and mem_readdatavalid never asserted. Expected: err=1 and done=1 exactly 255 cycles after entering WAIT. A second start clears err.
